// File: rtl/vga_rect_fill.sv
// vga_rect_fill: bus-programmed rectangle fill emitting one {colour,y,x} frame-buffer write per clock
module vga_rect_fill #(
  parameter int DISPLAY_WIDTH  = 800,
  parameter int DISPLAY_HEIGHT = 600
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic        bus_we,
  input  logic        bus_re,
  output logic [31:0] bus_rdata,
  input  logic        frame_trig,
  output logic [31:0] pix_wdata,
  output logic        pix_we,
  output logic        busy,
  output logic        done_irq
);
  typedef enum logic [1:0] {IDLE, ARM, FILL} state_t;
  localparam logic [10:0] XW = 11'(DISPLAY_WIDTH);
  localparam logic [10:0] YH = 11'(DISPLAY_HEIGHT);
  state_t state;
  logic [9:0] x0, y0, w, h;
  logic [11:0] colour;
  logic [10:0] cur_x, cur_y, x_end, y_end;
  logic done, ctrl_wr, go, abort, unused_bits;
  logic [31:0] rd_mux;
  assign unused_bits = ^bus_wdata[31:20];
  assign ctrl_wr = bus_we && bus_addr == 4'hC;
  assign abort = ctrl_wr && bus_wdata[2];
  assign go = ctrl_wr && bus_wdata[0] && !bus_wdata[2];
  assign x_end = {1'b0, x0} + {1'b0, w} - 11'd1;
  assign y_end = {1'b0, y0} + {1'b0, h} - 11'd1;
  assign busy = state != IDLE;
  assign pix_we = state == FILL && cur_x < XW && cur_y < YH;
  assign pix_wdata = {colour, cur_y[9:0], cur_x[9:0]};
  always_comb
    rd_mux = bus_addr == 4'h0 ? {12'b0, y0, x0} :
             bus_addr == 4'h4 ? {12'b0, h, w} :
             bus_addr == 4'h8 ? {20'b0, colour} :
             bus_addr == 4'hC ? {30'b0, done, busy} : 32'b0;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      {x0, y0, w, h, colour} <= '0;
      cur_x <= '0;
      cur_y <= '0;
      done <= 1'b0;
      done_irq <= 1'b0;
      bus_rdata <= '0;
    end else begin
      done_irq <= 1'b0;
      if (bus_re) bus_rdata <= rd_mux;
      if (bus_we && !busy && bus_addr == 4'h0) {y0, x0} <= bus_wdata[19:0];
      if (bus_we && !busy && bus_addr == 4'h4) {h, w} <= bus_wdata[19:0];
      if (bus_we && !busy && bus_addr == 4'h8) colour <= bus_wdata[11:0];
      if (abort) state <= IDLE;
      else if (state == IDLE && go) begin
        cur_x <= {1'b0, x0};
        cur_y <= {1'b0, y0};
        done <= w == 0 || h == 0;
        done_irq <= w == 0 || h == 0;
        state <= (w == 0 || h == 0) ? IDLE : bus_wdata[1] ? ARM : FILL;
      end else if (state == ARM && frame_trig) state <= FILL;
      else if (state == FILL) begin
        cur_x <= cur_x == x_end ? {1'b0, x0} : cur_x + 11'd1;
        if (cur_x == x_end) cur_y <= cur_y + 11'd1;
        if (cur_x == x_end && cur_y == y_end) begin
          state <= IDLE;
          done <= 1'b1;
          done_irq <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_vga_rect_fill.sv
// tb_vga_rect_fill: directed self-checking bench for vga_rect_fill
module tb_vga_rect_fill;
  logic clk = 0, rst = 0, bus_we = 0, bus_re = 0, frame_trig = 0;
  logic [3:0] bus_addr = 0;
  logic [31:0] bus_wdata = 0;
  logic [31:0] bus_rdata, pix_wdata;
  logic pix_we, busy, done_irq;
  int checks = 0, failures = 0;

  vga_rect_fill dut (.clk(clk), .rst(rst), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_we(bus_we), .bus_re(bus_re), .bus_rdata(bus_rdata), .frame_trig(frame_trig),
    .pix_wdata(pix_wdata), .pix_we(pix_we), .busy(busy), .done_irq(done_irq));

  always #5 clk = ~clk;

  task automatic stp;
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    bus_addr = a; bus_wdata = d; bus_we = 1;
    @(posedge clk); #1;
    bus_we = 0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    bus_addr = a; bus_re = 1;
    @(posedge clk); #1;
    bus_re = 0;
    d = bus_rdata;
  endtask

  function automatic logic [31:0] pix(input int c, input int x, input int y);
    return (32'(c) << 20) | (32'(y) << 10) | 32'(x);
  endfunction

  task automatic test_reset;
    logic [31:0] d;
    rst = 0;
    stp; stp;
    checks++;
    if ({pix_we, busy, done_irq} !== 3'b000 || pix_wdata !== 0 || bus_rdata !== 0) begin
      failures++;
      $display("FAIL reset_outputs: got we=%b busy=%b irq=%b wdata=%h rdata=%h, want all 0", pix_we, busy, done_irq, pix_wdata, bus_rdata);
    end
    rst = 1;
    stp;
    rd(4'h4, d);
    checks++;
    if (d !== 0) begin failures++; $display("FAIL reset_size: got %h want 0", d); end
    rd(4'hC, d);
    checks++;
    if (d !== 0) begin failures++; $display("FAIL reset_status: got %h want 0", d); end
  endtask

  task automatic test_basic_fill;
    logic [31:0] d;
    int xs[6] = '{10, 11, 12, 10, 11, 12};
    int ys[6] = '{20, 20, 20, 21, 21, 21};
    wr(4'h0, (20 << 10) | 10);
    wr(4'h4, (2 << 10) | 3);
    wr(4'h8, 32'hABC);
    wr(4'hC, 32'h1);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (pix_we !== 1 || pix_wdata !== pix(12'hABC, xs[i], ys[i]) || done_irq !== 0) begin
        failures++;
        $display("FAIL basic_pix%0d: got we=%b data=%h irq=%b want we=1 data=%h irq=0", i, pix_we, pix_wdata, done_irq, pix(12'hABC, xs[i], ys[i]));
      end
      stp;
    end
    checks++;
    if (pix_we !== 0 || busy !== 0 || done_irq !== 1) begin
      failures++;
      $display("FAIL basic_end: got we=%b busy=%b irq=%b want 0 0 1", pix_we, busy, done_irq);
    end
    stp;
    checks++;
    if (done_irq !== 0) begin failures++; $display("FAIL basic_irq_pulse: got %b want 0", done_irq); end
    rd(4'hC, d);
    checks++;
    if (d !== 32'h2) begin failures++; $display("FAIL basic_status: got %h want 2", d); end
  endtask

  task automatic test_clipping;
    int x, y;
    logic ew;
    wr(4'h0, (599 << 10) | 798);
    wr(4'h4, (2 << 10) | 4);
    wr(4'hC, 32'h1);
    for (int i = 0; i < 8; i++) begin
      x = 798 + i % 4; y = 599 + i / 4;
      ew = x < 800 && y < 600;
      checks++;
      if (pix_we !== ew || busy !== 1 || (ew && pix_wdata !== pix(12'hABC, x, y))) begin
        failures++;
        $display("FAIL clip_pix%0d: got we=%b busy=%b data=%h want we=%b busy=1 data=%h", i, pix_we, busy, pix_wdata, ew, pix(12'hABC, x, y));
      end
      stp;
    end
    checks++;
    if (busy !== 0 || done_irq !== 1) begin failures++; $display("FAIL clip_end: got busy=%b irq=%b want 0 1", busy, done_irq); end
  endtask

  task automatic test_zero_size;
    int irqs = 0, bad = 0;
    wr(4'h4, 5 << 10);
    bus_addr = 4'hC; bus_wdata = 1; bus_we = 1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      bus_we = 0;
      irqs += int'(done_irq);
      if (pix_we !== 0 || busy !== 0) bad++;
    end
    checks++;
    if (irqs !== 1 || bad !== 0) begin failures++; $display("FAIL zero_size: got irqs=%0d busy_or_we_cycles=%0d want 1 0", irqs, bad); end
  endtask

  task automatic test_frame_wait;
    int bad = 0;
    logic [31:0] d;
    wr(4'h0, (5 << 10) | 5);
    wr(4'h4, (1 << 10) | 2);
    frame_trig = 1;
    wr(4'hC, 32'h3);
    frame_trig = 0;
    for (int i = 0; i < 50; i++) begin
      if (pix_we !== 0 || busy !== 1) bad++;
      if (i == 10) wr(4'h4, (9 << 10) | 9); else stp;
    end
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL frame_armed: got %0d bad cycles want 0", bad); end
    frame_trig = 1;
    stp;
    frame_trig = 0;
    checks++;
    if (pix_we !== 1 || pix_wdata !== pix(12'hABC, 5, 5)) begin
      failures++;
      $display("FAIL frame_first: got we=%b data=%h want 1 %h", pix_we, pix_wdata, pix(12'hABC, 5, 5));
    end
    stp;
    checks++;
    if (pix_we !== 1 || pix_wdata !== pix(12'hABC, 6, 5)) begin
      failures++;
      $display("FAIL frame_second: got we=%b data=%h want 1 %h", pix_we, pix_wdata, pix(12'hABC, 6, 5));
    end
    stp;
    checks++;
    if (done_irq !== 1 || busy !== 0) begin failures++; $display("FAIL frame_done: got irq=%b busy=%b want 1 0", done_irq, busy); end
    rd(4'h4, d);
    checks++;
    if (d !== 32'h402) begin failures++; $display("FAIL frame_size_locked: got %h want 402", d); end
  endtask

  task automatic test_abort_reset;
    logic [31:0] d;
    wr(4'h0, 0);
    wr(4'h4, (10 << 10) | 10);
    wr(4'hC, 32'h1);
    stp; stp; stp;
    wr(4'hC, 32'h4);
    checks++;
    if (pix_we !== 0 || busy !== 0 || done_irq !== 0) begin
      failures++;
      $display("FAIL abort: got we=%b busy=%b irq=%b want 0 0 0", pix_we, busy, done_irq);
    end
    rd(4'hC, d);
    checks++;
    if (d !== 0) begin failures++; $display("FAIL abort_status: got %h want 0", d); end
    wr(4'hC, 32'h5);
    checks++;
    if (busy !== 0 || done_irq !== 0) begin failures++; $display("FAIL abort_over_go: got busy=%b irq=%b want 0 0", busy, done_irq); end
    wr(4'hC, 32'h1);
    checks++;
    if (pix_we !== 1 || pix_wdata !== pix(12'hABC, 0, 0)) begin
      failures++;
      $display("FAIL restart: got we=%b data=%h want 1 %h", pix_we, pix_wdata, pix(12'hABC, 0, 0));
    end
    stp; stp;
    #2 rst = 0;
    #1;
    checks++;
    if (pix_we !== 0 || busy !== 0) begin failures++; $display("FAIL async_reset: got we=%b busy=%b want 0 0", pix_we, busy); end
    stp;
    rst = 1;
    rd(4'h0, d);
    checks++;
    if (d !== 0) begin failures++; $display("FAIL reset_start: got %h want 0", d); end
  endtask

  task automatic test_go_while_busy;
    int cnt = 0, k = 0;
    wr(4'h4, (3 << 10) | 3);
    wr(4'hC, 32'h1);
    while (done_irq !== 1 && k < 50) begin
      cnt += int'(pix_we);
      if (k == 2) begin bus_addr = 4'hC; bus_wdata = 1; bus_we = 1; end
      else bus_we = 0;
      stp;
      k++;
    end
    bus_we = 0;
    checks++;
    if (cnt !== 9 || done_irq !== 1) begin failures++; $display("FAIL go_while_busy: got writes=%0d irq=%b want 9 1", cnt, done_irq); end
    stp;
    checks++;
    if (busy !== 0 || pix_we !== 0) begin failures++; $display("FAIL go_while_busy_idle: got busy=%b we=%b want 0 0", busy, pix_we); end
  endtask

  initial begin
    #1;
    test_reset;
    test_basic_fill;
    test_clipping;
    test_zero_size;
    test_frame_wait;
    test_abort_reset;
    test_go_while_busy;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
